// File: rtl/approximate_adder_8bit.sv
// 8-bit lower-part-OR approximate adder with a one-cycle registered result.
// Low APPROX_BITS bits use a carry-free OR; the upper bits ripple from a single carry guess.
module approximate_adder_8bit #(
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       out_valid
);

  localparam int unsigned K = APPROX_BITS;

  logic [7:0] sum_calc;
  logic [8:K] carry;
  logic [7:0] sum_d, sum_q;
  logic       cout_d, cout_q;
  logic       valid_d, valid_q;

  // Lower part: plain OR, no carry chain; cin folds into bit 0.
  for (genvar i = 0; i < K; i++) begin : g_lower
    if (i == 0) begin : g_bit0
      assign sum_calc[i] = A[i] | B[i] | cin;
    end else begin : g_bitn
      assign sum_calc[i] = A[i] | B[i];
    end
  end

  // Seed of the exact upper part: cin for the fully exact case, otherwise the guess
  // that the top approximate bit pair would have generated a carry.
  if (K == 0) begin : g_seed_cin
    assign carry[0] = cin;
  end else begin : g_seed_guess
    assign carry[K] = A[K-1] & B[K-1];
  end

  for (genvar i = K; i < 8; i++) begin : g_upper
    assign sum_calc[i] = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1]  = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_calc;
      cout_d = carry[8];
    end
  end

  // Reset wins over a simultaneous valid capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 8'd0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_approximate_adder_8bit.sv
// Self-checking bench: three instances (APPROX_BITS 0, 4, 8) share stimulus and are
// compared against an arithmetic reference model.
module tb_approximate_adder_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       cin_s;

  logic [7:0] sum_k  [3];
  logic       cout_k [3];
  logic       vld_k  [3];

  logic [7:0] exp_sum  [3];
  logic       exp_cout [3];
  logic       exp_vld;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam int unsigned KS [3] = '{0, 4, 8};

  approximate_adder_8bit #(.APPROX_BITS(0)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_s), .B(b_s), .cin(cin_s),
    .sum(sum_k[0]), .cout(cout_k[0]), .out_valid(vld_k[0])
  );
  approximate_adder_8bit #(.APPROX_BITS(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_s), .B(b_s), .cin(cin_s),
    .sum(sum_k[1]), .cout(cout_k[1]), .out_valid(vld_k[1])
  );
  approximate_adder_8bit #(.APPROX_BITS(8)) u_k8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_s), .B(b_s), .cin(cin_s),
    .sum(sum_k[2]), .cout(cout_k[2]), .out_valid(vld_k[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cout, sum} from the arithmetic rules: OR the low k bits, add the high parts plus guess.
  function automatic logic [8:0] loa_model(input int unsigned k, input logic [7:0] a,
                                           input logic [7:0] b, input logic c);
    int unsigned lo, hi, guess, full;
    if (k == 0) begin
      full = int'(a) + int'(b) + int'(c);
    end else begin
      lo    = (int'(a) | int'(b) | int'(c)) & ((1 << k) - 1);
      guess = ((int'(a) >> (k - 1)) & (int'(b) >> (k - 1))) & 1;
      hi    = (int'(a) >> k) + (int'(b) >> k) + guess;
      full  = (hi << k) | lo;
    end
    return full[8:0];
  endfunction

  // Apply one cycle of stimulus and advance the expected register state.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic v, input logic r);
    logic [8:0] m;
    @(negedge clk);
    a_s      = a;
    b_s      = b;
    cin_s    = c;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    if (r) begin
      exp_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_sum[i]  = 8'd0;
        exp_cout[i] = 1'b0;
      end
    end else begin
      exp_vld = v;
      if (v) begin
        for (int i = 0; i < 3; i++) begin
          m           = loa_model(KS[i], a, b, c);
          exp_sum[i]  = m[7:0];
          exp_cout[i] = m[8];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({cout_k[i], sum_k[i], vld_k[i]} !== 10'd0) begin
          n_fail++;
          $display("FAIL reset k=%0d: got cout=%0b sum=%0d vld=%0b, want all 0",
                   KS[i], cout_k[i], sum_k[i], vld_k[i]);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [6] = '{8'd65, 8'd71, 8'd84, 8'd200, 8'd255, 8'd8};
    logic [7:0] tb [6] = '{8'd76, 8'd66, 8'd73, 8'd100, 8'd1,   8'd8};
    logic [7:0] ts [6] = '{8'd141, 8'd135, 8'd157, 8'd44, 8'd255, 8'd24};
    logic       tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int n = 0; n < 6; n++) begin
      drive(ta[n], tb[n], 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (sum_k[1] !== ts[n] || cout_k[1] !== tc[n] || vld_k[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL directed k=4 %0d+%0d: got sum=%0d cout=%0b vld=%0b, want sum=%0d cout=%0b vld=1",
                 ta[n], tb[n], sum_k[1], cout_k[1], vld_k[1], ts[n], tc[n]);
      end
      for (int i = 0; i < 3; i += 2) begin
        n_checks++;
        if (sum_k[i] !== exp_sum[i] || cout_k[i] !== exp_cout[i] || vld_k[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL directed k=%0d %0d+%0d: got sum=%0d cout=%0b, want sum=%0d cout=%0b",
                   KS[i], ta[n], tb[n], sum_k[i], cout_k[i], exp_sum[i], exp_cout[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    drive(8'd200, 8'd100, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (sum_k[i] !== exp_sum[i] || cout_k[i] !== exp_cout[i] || vld_k[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold k=%0d: got sum=%0d cout=%0b vld=%0b, want sum=%0d cout=%0b vld=0",
                   KS[i], sum_k[i], cout_k[i], vld_k[i], exp_sum[i], exp_cout[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
    drive(8'd17, 8'd34, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({cout_k[i], sum_k[i], vld_k[i]} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_override k=%0d: got cout=%0b sum=%0d vld=%0b, want all 0",
                 KS[i], cout_k[i], sum_k[i], vld_k[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       c, v;
    for (int n = 0; n < 4000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      v = ($urandom_range(0, 7) != 0);
      drive(a, b, c, v, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (sum_k[i] !== exp_sum[i] || cout_k[i] !== exp_cout[i] || vld_k[i] !== exp_vld) begin
          n_fail++;
          $display("FAIL random k=%0d a=%0d b=%0d cin=%0b v=%0b: got sum=%0d cout=%0b vld=%0b, want sum=%0d cout=%0b vld=%0b",
                   KS[i], a, b, c, v, sum_k[i], cout_k[i], vld_k[i],
                   exp_sum[i], exp_cout[i], exp_vld);
        end
      end
      if (v) begin
        n_checks++;
        if ({cout_k[0], sum_k[0]} !== 9'(int'(a) + int'(b) + int'(c))) begin
          n_fail++;
          $display("FAIL exact_k0 a=%0d b=%0d cin=%0b: got %0d, want %0d",
                   a, b, c, {cout_k[0], sum_k[0]}, int'(a) + int'(b) + int'(c));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    for (int n = 0; n < 64; n++) begin
      a = 8'(n * 4);
      b = 8'(255 - n * 3);
      drive(a, b, n[0], 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (sum_k[i] !== exp_sum[i] || cout_k[i] !== exp_cout[i] || vld_k[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back k=%0d a=%0d b=%0d: got sum=%0d cout=%0b, want sum=%0d cout=%0b",
                   KS[i], a, b, sum_k[i], cout_k[i], exp_sum[i], exp_cout[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a_s      = 8'd0;
    b_s      = 8'd0;
    cin_s    = 1'b0;
    exp_vld  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_sum[i]  = 8'd0;
      exp_cout[i] = 1'b0;
    end
    test_reset();
    test_directed();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
